// File: rtl/ev_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ev_slot_scheduler
// Description : Round-robin allocator of a pool of EV charging slots. Tracks
//               each slot as FREE / BUSY / FAULT with a session timer and
//               releases slots on charge-complete, fault or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ev_slot_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [2:0]           gnt_slot_o,
    input  logic [NUM_SLOTS-1:0] slot_done_i,
    input  logic [NUM_SLOTS-1:0] slot_fault_i,
    output logic [NUM_SLOTS-1:0] slot_busy_o,
    output logic [NUM_SLOTS-1:0] slot_faulted_o,
    output logic [NUM_SLOTS-1:0] slot_timeout_o,
    output logic [3:0]           free_count_o
);

    localparam int              RW         = $clog2(NUM_REQ);
    localparam int              TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]   REQ_LAST   = RW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FAULT = 2'd2
    } slot_state_e;

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic [TW-1:0]        timer_q [NUM_SLOTS];
    logic [TW-1:0]        timer_d [NUM_SLOTS];
    logic [RW-1:0]        owner_q [NUM_SLOTS];
    logic [RW-1:0]        owner_d [NUM_SLOTS];
    logic [NUM_REQ-1:0]   owns_q,  owns_d;
    logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [2:0]           gnt_slot_q, gnt_slot_d;
    logic [NUM_SLOTS-1:0] timeout_q, timeout_d;
    logic [3:0]           free_count_q, free_count_d;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_req_found;
    logic [RW-1:0]        w_winner;
    int                   w_best;
    int                   w_dist;
    logic                 w_slot_found;
    logic [2:0]           w_slot_idx;
    logic                 w_gnt_valid;
    logic [NUM_SLOTS-1:0] w_slot_release;

    // Pick the eligible requester closest to rr_ptr going upward with wrap.
    always_comb begin
        w_elig      = req_i & ~owns_q;
        w_req_found = 1'b0;
        w_winner    = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            w_dist = r - int'(rr_ptr_q);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (w_elig[r] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_req_found = 1'b1;
                w_winner    = RW'(r);
            end
        end
    end

    // Lowest-index slot that is FREE in the registered state.
    always_comb begin
        w_slot_found = 1'b0;
        w_slot_idx   = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (state_q[s] == S_FREE) begin
                w_slot_found = 1'b1;
                w_slot_idx   = 3'(s);
            end
        end
        w_gnt_valid = w_req_found && w_slot_found;
    end

    // Per-slot session FSM: fault beats done, done beats timeout.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_d[s]        = state_q[s];
            timer_d[s]        = timer_q[s];
            owner_d[s]        = owner_q[s];
            w_slot_release[s] = 1'b0;
            timeout_d[s]      = 1'b0;
            case (state_q[s])
                S_FREE: begin
                    timer_d[s] = '0;
                    if (w_gnt_valid && (w_slot_idx == 3'(s))) begin
                        state_d[s] = S_BUSY;
                        owner_d[s] = w_winner;
                    end else if (slot_fault_i[s]) begin
                        state_d[s] = S_FAULT;
                    end
                end
                S_BUSY: begin
                    if (slot_fault_i[s]) begin
                        state_d[s]        = S_FAULT;
                        timer_d[s]        = '0;
                        w_slot_release[s] = 1'b1;
                    end else if (slot_done_i[s]) begin
                        state_d[s]        = S_FREE;
                        timer_d[s]        = '0;
                        w_slot_release[s] = 1'b1;
                    end else if (timer_q[s] == TIMER_LAST) begin
                        state_d[s]        = S_FREE;
                        timer_d[s]        = '0;
                        w_slot_release[s] = 1'b1;
                        timeout_d[s]      = 1'b1;
                    end else begin
                        timer_d[s] = timer_q[s] + TW'(1);
                    end
                end
                S_FAULT: begin
                    timer_d[s] = '0;
                    if (!slot_fault_i[s]) begin
                        state_d[s] = S_FREE;
                    end
                end
                default: begin
                    state_d[s] = S_FREE;
                    timer_d[s] = '0;
                end
            endcase
        end
    end

    // Ownership bookkeeping, grant outputs, pointer advance and free count.
    always_comb begin
        owns_d = owns_q;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_slot_release[s] && (owner_q[s] == RW'(r))) begin
                    owns_d[r] = 1'b0;
                end
            end
        end
        gnt_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_gnt_valid && (w_winner == RW'(r))) begin
                gnt_d[r]  = 1'b1;
                owns_d[r] = 1'b1;
            end
        end
        gnt_slot_d = w_gnt_valid ? w_slot_idx : 3'd0;
        if (w_gnt_valid) begin
            rr_ptr_d = (w_winner == REQ_LAST) ? '0 : (w_winner + RW'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        free_count_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (state_d[s] == S_FREE) begin
                free_count_d = free_count_d + 4'd1;
            end
        end
    end

    // State registers; reset drops every session without pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= S_FREE;
                timer_q[s] <= '0;
                owner_q[s] <= '0;
            end
            owns_q       <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            gnt_slot_q   <= '0;
            timeout_q    <= '0;
            free_count_q <= 4'(NUM_SLOTS);
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= state_d[s];
                timer_q[s] <= timer_d[s];
                owner_q[s] <= owner_d[s];
            end
            owns_q       <= owns_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            gnt_slot_q   <= gnt_slot_d;
            timeout_q    <= timeout_d;
            free_count_q <= free_count_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot_flags
        assign slot_busy_o[s]    = (state_q[s] == S_BUSY);
        assign slot_faulted_o[s] = (state_q[s] == S_FAULT);
    end

    assign gnt_o          = gnt_q;
    assign gnt_slot_o     = gnt_slot_q;
    assign slot_timeout_o = timeout_q;
    assign free_count_o   = free_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ev_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev_slot_scheduler
// Description : Self-checking bench for ev_slot_scheduler: directed vector
//               table, timeout and async-reset sequences, random traffic
//               compared against a session-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ev_slot_scheduler;

    localparam int TO = 8;

    logic       clk_i;
    logic       reset_n_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [2:0] gnt_slot_o;
    logic [3:0] slot_done_i;
    logic [3:0] slot_fault_i;
    logic [3:0] slot_busy_o;
    logic [3:0] slot_faulted_o;
    logic [3:0] slot_timeout_o;
    logic [3:0] free_count_o;

    ev_slot_scheduler #(
        .NUM_REQ   (4),
        .NUM_SLOTS (4),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .gnt_slot_o     (gnt_slot_o),
        .slot_done_i    (slot_done_i),
        .slot_fault_i   (slot_fault_i),
        .slot_busy_o    (slot_busy_o),
        .slot_faulted_o (slot_faulted_o),
        .slot_timeout_o (slot_timeout_o),
        .free_count_o   (free_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot status 0=free 1=busy 2=fault, session start edge
    int         m_state [4];
    int         m_owner [4];
    int         m_start [4];
    bit   [3:0] m_owns;
    int         m_rr;
    logic [3:0] m_gnt;
    logic [2:0] m_gslot;
    logic [3:0] m_timeout;
    int         edge_n = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] fault;
        logic [3:0] gnt;
        logic [2:0] gslot;
        logic [3:0] busy;
        logic [3:0] faulted;
        logic [3:0] free;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_state[s] = 0;
            m_owner[s] = 0;
            m_start[s] = 0;
        end
        m_owns    = '0;
        m_rr      = 0;
        m_gnt     = '0;
        m_gslot   = '0;
        m_timeout = '0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic [3:0] dn, input logic [3:0] ft);
        int winner;
        int slot;
        int r;
        int ns [4];
        bit [3:0] clr;
        winner = -1;
        slot   = -1;
        for (int k = 0; k < 4; k++) begin
            r = (m_rr + k) % 4;
            if (winner < 0 && rq[r] && !m_owns[r]) winner = r;
        end
        for (int s = 0; s < 4; s++) begin
            if (slot < 0 && m_state[s] == 0) slot = s;
        end
        if (slot < 0) winner = -1;
        m_timeout = '0;
        clr       = '0;
        for (int s = 0; s < 4; s++) begin
            ns[s] = m_state[s];
            if (m_state[s] == 0) begin
                if (winner >= 0 && s == slot) begin
                    ns[s]      = 1;
                    m_owner[s] = winner;
                    m_start[s] = edge_n;
                end else if (ft[s]) begin
                    ns[s] = 2;
                end
            end else if (m_state[s] == 1) begin
                if (ft[s]) begin
                    ns[s] = 2;
                    clr[m_owner[s]] = 1'b1;
                end else if (dn[s]) begin
                    ns[s] = 0;
                    clr[m_owner[s]] = 1'b1;
                end else if (edge_n - m_start[s] == TO) begin
                    ns[s] = 0;
                    clr[m_owner[s]] = 1'b1;
                    m_timeout[s] = 1'b1;
                end
            end else begin
                if (!ft[s]) ns[s] = 0;
            end
        end
        m_owns = m_owns & ~clr;
        if (winner >= 0) begin
            m_owns[winner] = 1'b1;
            m_gnt   = 4'(1 << winner);
            m_gslot = 3'(slot);
            m_rr    = (winner + 1) % 4;
        end else begin
            m_gnt   = '0;
            m_gslot = '0;
        end
        for (int s = 0; s < 4; s++) m_state[s] = ns[s];
    endtask

    task automatic check_model(input string tag);
        logic [3:0] busy;
        logic [3:0] flt;
        logic [3:0] fr;
        busy = '0;
        flt  = '0;
        fr   = '0;
        for (int s = 0; s < 4; s++) begin
            busy[s] = (m_state[s] == 1);
            flt[s]  = (m_state[s] == 2);
            if (m_state[s] == 0) fr = fr + 4'd1;
        end
        chk({tag, ".gnt"},      gnt_o,          m_gnt);
        chk({tag, ".gnt_slot"}, gnt_slot_o,     m_gslot);
        chk({tag, ".busy"},     slot_busy_o,    busy);
        chk({tag, ".faulted"},  slot_faulted_o, flt);
        chk({tag, ".timeout"},  slot_timeout_o, m_timeout);
        chk({tag, ".free"},     free_count_o,   fr);
    endtask

    // Apply inputs, take one rising edge, advance the model, settle.
    task automatic step(input logic [3:0] rq, input logic [3:0] dn, input logic [3:0] ft);
        req_i        = rq;
        slot_done_i  = dn;
        slot_fault_i = ft;
        @(posedge clk_i);
        edge_n++;
        if (reset_n_i) model_step(rq, dn, ft);
        else model_reset();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] f;
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0001, 4'b0000, 4'd3};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 3'd1, 4'b0011, 4'b0000, 4'd2};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 3'd2, 4'b0111, 4'b0000, 4'd1};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 3'd3, 4'b1111, 4'b0000, 4'd0};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b1111, 4'b0000, 4'd0};
        tbl[5]  = '{4'b1111, 4'b0100, 4'b0000, 4'b0000, 3'd0, 4'b1011, 4'b0000, 4'd1};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 3'd2, 4'b1111, 4'b0000, 4'd0};
        tbl[7]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'd0, 4'b0000, 4'b0000, 4'd4};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 3'd0, 4'b0001, 4'b0000, 4'd3};
        tbl[9]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 3'd1, 4'b0011, 4'b0000, 4'd2};
        tbl[10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 3'd0, 4'b0001, 4'b0010, 4'd2};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 3'd0, 4'b0001, 4'b0010, 4'd2};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0001, 4'b0000, 4'd3};
        tbl[13] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 3'd1, 4'b0011, 4'b0000, 4'd2};
        tbl[14] = '{4'b0000, 4'b0011, 4'b0000, 4'b0000, 3'd0, 4'b0000, 4'b0000, 4'd4};

        model_reset();
        reset_n_i    = 1'b0;
        req_i        = '0;
        slot_done_i  = '0;
        slot_fault_i = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom));
            chk("rst.gnt",     gnt_o,          4'b0000);
            chk("rst.slot",    gnt_slot_o,     3'd0);
            chk("rst.busy",    slot_busy_o,    4'b0000);
            chk("rst.faulted", slot_faulted_o, 4'b0000);
            chk("rst.timeout", slot_timeout_o, 4'b0000);
            chk("rst.free",    free_count_o,   4'd4);
        end
        reset_n_i = 1'b1;

        // Directed vector table: round-robin, pool full, release, fault priority
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, tbl[i].done, tbl[i].fault);
            chk($sformatf("v%0d.gnt", i),     gnt_o,          tbl[i].gnt);
            chk($sformatf("v%0d.slot", i),    gnt_slot_o,     tbl[i].gslot);
            chk($sformatf("v%0d.busy", i),    slot_busy_o,    tbl[i].busy);
            chk($sformatf("v%0d.faulted", i), slot_faulted_o, tbl[i].faulted);
            chk($sformatf("v%0d.free", i),    free_count_o,   tbl[i].free);
            check_model($sformatf("v%0d.m", i));
        end

        // Timeout: session granted at edge g ends after edge g+TO
        step(4'b0001, 4'b0000, 4'b0000);
        chk("to.gnt",  gnt_o,      4'b0001);
        chk("to.slot", gnt_slot_o, 3'd0);
        for (int i = 1; i < TO; i++) begin
            step(4'b0000, 4'b0000, 4'b0000);
            chk($sformatf("to.busy%0d", i), slot_busy_o[0],    1'b1);
            chk($sformatf("to.tmo%0d", i),  slot_timeout_o,    4'b0000);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        chk("to.pulse", slot_timeout_o, 4'b0001);
        chk("to.busy",  slot_busy_o,    4'b0000);
        chk("to.free",  free_count_o,   4'd4);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("to.pulse_end", slot_timeout_o, 4'b0000);

        // Random traffic against the model
        f = '0;
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] dn;
            for (int s = 0; s < 4; s++) begin
                if (f[s]) f[s] = ($urandom_range(0, 9) < 7);
                else      f[s] = ($urandom_range(0, 99) < 3);
                dn[s] = ($urandom_range(0, 9) == 0);
            end
            step(4'($urandom), dn, f);
            check_model("rnd");
        end

        // Asynchronous reset in the middle of three sessions
        reset_n_i = 1'b0;
        step(4'b0000, 4'b0000, 4'b0000);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'b0111, 4'b0000, 4'b0000);
            check_model("ar.setup");
        end
        chk("ar.busy3", slot_busy_o, 4'b0111);
        #3;
        reset_n_i = 1'b0;
        #1;
        model_reset();
        chk("ar.busy",    slot_busy_o,    4'b0000);
        chk("ar.gnt",     gnt_o,          4'b0000);
        chk("ar.free",    free_count_o,   4'd4);
        chk("ar.timeout", slot_timeout_o, 4'b0000);
        for (int i = 0; i < TO + 2; i++) begin
            step(4'b0111, 4'b0000, 4'b0000);
            chk($sformatf("ar.hold_tmo%0d", i), slot_timeout_o, 4'b0000);
            chk($sformatf("ar.hold_busy%0d", i), slot_busy_o,   4'b0000);
        end
        reset_n_i = 1'b1;
        step(4'b0001, 4'b0000, 4'b0000);
        chk("ar.regrant",      gnt_o,      4'b0001);
        chk("ar.regrant_slot", gnt_slot_o, 3'd0);
        check_model("ar.m");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ev_slot_scheduler.md
# ev_slot_scheduler

Shares a pool of charging slots among multiple vehicle requesters. It arbitrates round-robin, tracks each slot's session (free, busy, faulted) with a per-slot session timer, and releases slots on charge-complete, fault or timeout. It sits between the vehicle-facing request logic and the per-slot charging controllers: it issues slot assignments and consumes their done/fault indications.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_SLOTS, 4, number of charging slots (1..8)
- TIMEOUT, 1000, maximum busy cycles per session before forced release (≥2)
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous assert, active-low; all state cleared while low
- req  in  NUM_REQ  per-requester level request; ignored for a requester that currently owns a slot
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- gnt_slot  out  3  slot index of the current grant; valid only when gnt != 0, else 0
- slot_done  in  NUM_SLOTS  per-slot charge-complete pulse from slot controller
- slot_fault  in  NUM_SLOTS  per-slot fault level from slot controller
- slot_busy  out  NUM_SLOTS  slot in BUSY state
- slot_faulted  out  NUM_SLOTS  slot in FAULT state
- slot_timeout  out  NUM_SLOTS  one-cycle pulse when a session is force-released by timeout
- free_count  out  4  number of slots in FREE state

## Operation
- Per-slot FSM, states FREE, BUSY, FAULT:
  - FREE→BUSY on grant to this slot.
  - FREE→FAULT when slot_fault=1.
  - BUSY→FAULT when slot_fault=1. Fault has priority over done and timeout in the same cycle.
  - BUSY→FREE when slot_done=1, or when the timer reaches TIMEOUT-1 (slot_timeout pulses).
  - FAULT→FREE on the first cycle slot_fault=0.
- slot_done on a FREE or FAULT slot is ignored.
- Each slot stores the owner requester index. Each requester has an owns bit: set on grant, cleared when its slot leaves BUSY for any reason.
- Arbitration, every cycle:
  - Eligible requesters: req=1 and owns=0.
  - Search begins at rr_ptr and wraps modulo NUM_REQ. The first eligible requester wins.
  - If any slot is FREE, grant the winner the lowest-index FREE slot.
  - Maximum one grant per cycle.
  - On a grant, rr_ptr ← winner+1 mod NUM_REQ. With no grant, rr_ptr holds.
- Slot freedom for arbitration uses the registered state only. A slot released in cycle t becomes grantable from cycle t+1.
- Session timer, width clog2(TIMEOUT):
  - Cleared to 0 on grant.
  - Increments each cycle in BUSY.
  - Held at 0 in FREE and FAULT.
  - Never wraps: the release at TIMEOUT-1 prevents overflow.
- free_count = popcount of FREE slots, registered alongside state.
- Reset values: gnt=0, gnt_slot=0, slot_busy=0, slot_faulted=0, slot_timeout=0, free_count=NUM_SLOTS, rr_ptr=0, all owns=0, all timers=0, all slots FREE.
- Reset mid-session drops every session immediately. No done or timeout pulse is generated.

## Timing
- Grant latency: req sampled at edge t; gnt, gnt_slot and slot_busy are high after edge t, with one cycle of latency.
- The requester must deassert or keep req; either way it is not re-granted while it owns a slot.
- Release latency: slot_done or slot_fault sampled at edge t; slot_busy falls (and slot_faulted rises) after edge t. The owner becomes eligible for the arbitration evaluated in the cycle after release.
- Timeout: with a grant at edge g, slot_timeout pulses and slot_busy falls after edge g+TIMEOUT, so the session occupies TIMEOUT cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Pool full (free_count=0): no gnt, requests remain pending, rr_ptr unchanged.
- Release and new grant in the same cycle: the grant uses only slots that were FREE before the edge.

## Test plan
- Reset: hold reset_n=0 with random inputs → all outputs at reset values, free_count=4. Release reset, req=0001 → gnt=0001, gnt_slot=0 on the next cycle.
- Round-robin: req=1111 held, 4 slots free → grants 0001 (slot0), 0010 (slot1), 0100 (slot2), 1000 (slot3) on consecutive cycles, then free_count=0 and no further gnt.
- Pool full then release: all slots busy, req[0]=1 pending, slot_done[2] pulse → slot_busy[2]=0 next cycle, then gnt=0001, gnt_slot=2 one cycle later.
- Timeout: TIMEOUT=8, single grant at cycle 0 → slot_timeout[0] pulse and slot_busy[0]=0 at cycle 8, free_count back to 4.
- Fault priority: slot_done[1] and slot_fault[1] asserted together on a busy slot → slot_faulted[1]=1, no release to FREE. Drop fault → slot FREE next cycle, owner re-granted if still requesting.
- Async reset mid-session: reset_n pulled low between edges with 3 slots busy → outputs clear immediately, no slot_timeout pulse.
